// File: rtl/comparator.sv
// Registered 2-bit unsigned magnitude comparator: X = {A,B} vs Y = {C,D}.
// Produces one-hot EQ/GT/LT flags one clock after the operands are sampled.
module comparator (
  input  logic input_clk,
  input  logic input_reset,
  input  logic input_A,
  input  logic input_B,
  input  logic input_C,
  input  logic input_D,
  output logic output_EQ,
  output logic output_GT,
  output logic output_LT
);

  logic [1:0] x;
  logic [1:0] y;
  logic       eq_n;
  logic       gt_n;
  logic       lt_n;

  assign x = {input_A, input_B};
  assign y = {input_C, input_D};

  // MSB decides first; on a tie the LSB decides.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    eq_n = 1'b0;
    gt_n = 1'b0;
    lt_n = 1'b0;
    if (x[1] != y[1]) begin
      gt_n = x[1];
      lt_n = y[1];
    end else if (x[0] != y[0]) begin
      gt_n = x[0];
      lt_n = y[0];
    end else begin
      eq_n = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge input_clk) begin
    if (input_reset) begin
      output_EQ <= 1'b0;
      output_GT <= 1'b0;
      output_LT <= 1'b0;
    end else begin
      output_EQ <= eq_n;
      output_GT <= gt_n;
      output_LT <= lt_n;
    end
  end

endmodule

// File: tb/tb_comparator.sv
// Self-checking bench for comparator: reset, exhaustive table sweep, MSB priority,
// latency and mid-run reset sequences, plus a per-cycle one-hot/reset monitor.
module tb_comparator;

  logic clk;
  logic rst;
  logic a, b, c, d;
  logic eq, gt, lt;

  int tests = 0;
  int fails = 0;

  // Bench-side knowledge of whether the last edge was a non-reset edge.
  logic exp_valid = 1'b0;

  comparator dut (
    .input_clk  (clk),
    .input_reset(rst),
    .input_A    (a),
    .input_B    (b),
    .input_C    (c),
    .input_D    (d),
    .output_EQ  (eq),
    .output_GT  (gt),
    .output_LT  (lt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] abcd;
    logic [2:0] flags;  // {eq, gt, lt}
  } vec_t;

  localparam logic [2:0] F_EQ = 3'b100;
  localparam logic [2:0] F_GT = 3'b010;
  localparam logic [2:0] F_LT = 3'b001;
  localparam logic [2:0] F_0  = 3'b000;

  vec_t vecs [16];

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    {a, b, c, d} = v;
  endtask

  always @(posedge clk) exp_valid = !rst;

  // Every cycle: after a non-reset edge exactly one flag is set, otherwise all clear.
  always @(negedge clk) begin
    if (exp_valid)
      check("onehot", 3'($countones({eq, gt, lt})), 3'd1);
    else
      check("reset_zero", {eq, gt, lt}, F_0);
  end

  initial begin
    vecs[0]  = '{4'b0000, F_EQ};
    vecs[1]  = '{4'b0001, F_LT};
    vecs[2]  = '{4'b0010, F_LT};
    vecs[3]  = '{4'b0011, F_LT};
    vecs[4]  = '{4'b0100, F_GT};
    vecs[5]  = '{4'b0101, F_EQ};
    vecs[6]  = '{4'b0110, F_LT};
    vecs[7]  = '{4'b0111, F_LT};
    vecs[8]  = '{4'b1000, F_GT};
    vecs[9]  = '{4'b1001, F_GT};
    vecs[10] = '{4'b1010, F_EQ};
    vecs[11] = '{4'b1011, F_LT};
    vecs[12] = '{4'b1100, F_GT};
    vecs[13] = '{4'b1101, F_GT};
    vecs[14] = '{4'b1110, F_GT};
    vecs[15] = '{4'b1111, F_EQ};

    // Reset held for 2 clocks with X=2, Y=0.
    rst = 1'b1;
    drive(4'b1000);
    repeat (2) begin
      @(posedge clk); #1;
      check("reset_hold", {eq, gt, lt}, F_0);
    end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("reset_release_gt", {eq, gt, lt}, F_GT);

    // Exhaustive sweep, each vector held three clocks.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk) drive(vecs[i].abcd);
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        check($sformatf("sweep_%b_clk%0d", vecs[i].abcd, k), {eq, gt, lt}, vecs[i].flags);
      end
    end

    // MSB priority: X=2, Y=1 and swapped.
    @(negedge clk) drive(4'b1001);
    @(posedge clk); #1;
    check("msb_x2_y1", {eq, gt, lt}, F_GT);
    @(negedge clk) drive(4'b0110);
    @(posedge clk); #1;
    check("msb_x1_y2", {eq, gt, lt}, F_LT);

    // Latency: change 0000 -> 0011 just after an edge.
    @(negedge clk) drive(4'b0000);
    @(posedge clk); #1;
    check("lat_eq_before", {eq, gt, lt}, F_EQ);
    drive(4'b0011);
    #2;
    check("lat_eq_hold", {eq, gt, lt}, F_EQ);
    @(negedge clk); #1;
    check("lat_eq_hold_neg", {eq, gt, lt}, F_EQ);
    @(posedge clk); #1;
    check("lat_lt_after", {eq, gt, lt}, F_LT);

    // Mid-run reset with X=3, Y=0.
    @(negedge clk) drive(4'b1100);
    @(posedge clk); #1;
    check("midrst_gt_before", {eq, gt, lt}, F_GT);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_clear", {eq, gt, lt}, F_0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("midrst_gt_after", {eq, gt, lt}, F_GT);

    @(negedge clk);
    @(posedge clk); #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
